// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL lock qualifier: FSM state encoding,
// counter width helper and the lock-loss counter width.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int LOSS_CNT_W = 8;

  // Width needed to count 0..max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_reset_ce_sync_bit.sv
// N-flop single-bit synchroniser with asynchronous active-high reset to 0.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pll_lock_reset_ce.sv
// Lock-qualified core reset and divided clock enables from the PLL locked flag.
// Optional build macro PLL_LOCK_LOSS_CNT_EN adds an 8-bit saturating RUN-loss counter.
module pll_lock_reset_ce
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 256,
  parameter int CE_DIV        = 10,
  parameter int CPU_RATIO     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       core_rst,
  output logic       ce_pix,
  output logic       ce_cpu,
`ifdef PLL_LOCK_LOSS_CNT_EN
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
`endif
  output logic [1:0] state
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam int PIX_W = cnt_width(CE_DIV, 1);
  localparam int CPU_W = cnt_width(CPU_RATIO, 1);

  logic             lk;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CPU_W-1:0] cpu_q, cpu_d;
  logic             core_rst_q, core_rst_d;
  logic             ce_pix_q, ce_pix_d;
  logic             ce_cpu_q, ce_cpu_d;
  logic             tick_ce;
  logic             pix_wrap;
  logic             cpu_wrap;

  sync_bit #(.N(SYNC_STAGES)) u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  assign pix_wrap = (pix_q == PIX_W'(CE_DIV - 1));
  assign cpu_wrap = (cpu_q == CPU_W'(CPU_RATIO - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pix_d    = pix_q;
    cpu_d    = cpu_q;
    ce_pix_d = 1'b0;
    ce_cpu_d = 1'b0;
    tick_ce  = 1'b0;

    case (state_q)
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      end
      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          // Divider phase restarts here so every relock yields the same CE timing.
          state_d = HOLD;
          cnt_d   = '0;
          pix_d   = '0;
          cpu_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else begin
          tick_ce = 1'b1;
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else begin
          tick_ce = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (tick_ce) begin
      ce_pix_d = pix_wrap;
      pix_d    = pix_wrap ? '0 : pix_q + PIX_W'(1);
      if (pix_wrap) begin
        ce_cpu_d = cpu_wrap;
        cpu_d    = cpu_wrap ? '0 : cpu_q + CPU_W'(1);
      end
    end

    core_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      pix_q      <= '0;
      cpu_q      <= '0;
      core_rst_q <= 1'b1;
      ce_pix_q   <= 1'b0;
      ce_cpu_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      cpu_q      <= cpu_d;
      core_rst_q <= core_rst_d;
      ce_pix_q   <= ce_pix_d;
      ce_cpu_q   <= ce_cpu_d;
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == RUN) && (state_d == WAIT_LOCK) && (loss_q != '1)) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign lock_loss_cnt = loss_q;
`endif

  assign core_rst = core_rst_q;
  assign ce_pix   = ce_pix_q;
  assign ce_cpu   = ce_cpu_q;
  assign state    = state_q;

endmodule

// File: doc/pll_lock_reset_ce.md
Name: pll_lock_reset_ce

Overview:
Consumes the PLL `locked` output and turns it into a clean, lock-qualified core reset plus phase-aligned clock enables.
- Sits directly after the PLL wrapper, in the 60 MHz system-clock domain; every core block takes its reset and CEs from here.
- Qualifies lock with a stability window and a post-lock hold, then derives pixel and CPU clock enables by integer division.
- Loss of lock at any time reasserts core reset and stops the enables.

Parameters:
SYNC_STAGES, 2, flops in the `pll_locked` synchroniser (>=2)
STABLE_CYCLES, 1024, cycles `locked` must stay high before the hold phase starts (>=1)
HOLD_CYCLES, 256, cycles core reset stays asserted with CEs running (>=1)
CE_DIV, 10, system clocks per `ce_pix` pulse (>=1; 1 means `ce_pix` is constantly high while running)
CPU_RATIO, 4, `ce_pix` pulses per `ce_cpu` pulse (>=1)

Ports:
clk  in  1  system clock (PLL outclk_0, 60 MHz)
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL lock indicator, asynchronous to `clk`
core_rst  out  1  active-high synchronous reset for the core
ce_pix  out  1  single-cycle pixel clock enable
ce_cpu  out  1  single-cycle CPU clock enable, coincident with a `ce_pix` pulse
state  out  2  current FSM state, for debug

Behaviour:
- Reset: asynchronous and active-high; one clock.
  - While `rst`=1: all synchroniser flops 0, state=WAIT_LOCK, `core_rst`=1, `ce_pix`=0, `ce_cpu`=0, all counters 0.
- Synchroniser: `pll_locked` passes through SYNC_STAGES flops to give `lk`. FSM acts only on `lk`.
- FSM encoding: WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3. All outputs are registered.
  - WAIT_LOCK: when `lk`=1, go to STABLE with the window counter cleared.
  - STABLE: window counter increments each cycle.
    - `lk`=0 → WAIT_LOCK.
    - Counter == STABLE_CYCLES-1 → HOLD; hold counter and CE counters cleared.
  - HOLD: `core_rst` stays 1; CE dividers run; hold counter increments.
    - `lk`=0 → WAIT_LOCK.
    - Counter == HOLD_CYCLES-1 → RUN.
  - RUN: `core_rst`=0; CEs run. `lk`=0 → WAIT_LOCK.
- `core_rst`:
  - Is 1 in every state except RUN.
  - Falls on the same edge that enters RUN.
  - Rises on the same edge that leaves RUN, i.e. one edge after `lk` drops.
- Latency: `core_rst` falls SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges after the first edge that samples `pll_locked`=1.
- CE divider:
  - Only active in HOLD and RUN.
  - Pixel counter runs 0..CE_DIV-1 and wraps; `ce_pix`=1 on the cycle the counter equals CE_DIV-1. The first pulse is CE_DIV cycles after HOLD entry.
  - CPU counter advances on each `ce_pix`, wrapping at CPU_RATIO-1. `ce_cpu`=1 together with the `ce_pix` pulse on which the CPU counter equals CPU_RATIO-1.
  - `ce_cpu` is never high without `ce_pix`.
- Leaving HOLD or RUN for WAIT_LOCK:
  - CEs are forced to 0 from that edge on.
  - Divider counters reset on the next HOLD entry, so phase is deterministic after each relock.
- Glitches: a `lk` low pulse of a single cycle in any state past WAIT_LOCK restarts the whole sequence. There is no filtering beyond the stability window.
- `rst` asserted mid-sequence: immediate return to the reset values above.

Optional Feature:
Macro: PLL_LOCK_LOSS_CNT_EN
- Defined:
  - Adds output port `lock_loss_cnt` (8 bits).
  - Increments by one on each transition from RUN to WAIT_LOCK.
  - Saturates at 255; cleared only by `rst`.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package `pll_rst_pkg`:
  - state enum (WAIT_LOCK/STABLE/HOLD/RUN, 2 bits);
  - counter width helper using clog2 of max(STABLE_CYCLES, HOLD_CYCLES);
  - constant LOSS_CNT_W=8.
- Sub-module `sync_bit`: parameterised N-flop synchroniser with async active-high reset to 0, reusable elsewhere in the core.
- FSM and CE dividers stay in the top module.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CE_DIV=3, CPU_RATIO=2.
- Power-up: `rst`=1 for 5 cycles, `pll_locked`=1 from cycle 0 → `core_rst`=1 and CEs 0 during `rst`; `core_rst` falls exactly 15 edges after `rst` release; `state` steps 0→1→2→3.
- CE cadence: in RUN, sample 24 cycles → `ce_pix` pulses every 3rd cycle (8 pulses), `ce_cpu` on every 2nd `ce_pix` (4 pulses); first `ce_pix` 3 cycles after HOLD entry.
- Unstable lock: `pll_locked` high 5 cycles, low 1, then high → FSM returns to WAIT_LOCK; `core_rst` falls 15 edges after the final rise, never earlier.
- Lock loss in RUN: drop `pll_locked` → `core_rst`=1 and CEs 0 on edge 3 after the drop; relock → full 15-edge sequence and CE phase identical to the first power-up.
- Async reset mid-HOLD: assert `rst` between edges → `core_rst`=1, CEs 0, `state`=0 without waiting for a clock edge.
- With PLL_LOCK_LOSS_CNT_EN: 3 RUN→loss cycles → `lock_loss_cnt`=3; force 300 losses → saturates at 255.
